// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch unit sitting behind the PC register.
//
// Reads the 32-bit instruction at pc_i one byte per request through a shared,
// byte-wide synchronous memory port. It requests a stall until the instruction
// for pc_i is held in its buffer. It presents that instruction, its pc and its
// jump flag to the IF/ID register.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous reset, active low
//   pc_i         current pc
//   jump_i       pc_i came from a jump target (captured when a fetch starts)
//   stall        pipeline stall vector; only stall[1] is used (holds IF outputs)
//   mem_a        byte address of the memory request
//   mem_rd_en    memory read request valid
//   mem_grant    request accepted this cycle
//   mem_din      read data, valid the cycle after an accepted request
//   if_stallreq  high while no completed instruction exists for pc_i
//   inst_o       buffered instruction, little-endian
//   inst_pc_o    pc of inst_o
//   inst_jump_o  jump flag captured with inst_o's fetch
//   inst_valid_o inst_o belongs to pc_i
module if_fetch #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned BYTES  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] pc_i,
   input  logic              jump_i,
   input  logic [4:0]        stall,
   output logic [ADDR_W-1:0] mem_a,
   output logic              mem_rd_en,
   input  logic              mem_grant,
   input  logic [7:0]        mem_din,
   output logic              if_stallreq,
   output logic [31:0]       inst_o,
   output logic [ADDR_W-1:0] inst_pc_o,
   output logic              inst_jump_o,
   output logic              inst_valid_o
);

   if (BYTES != 4) begin : g_bytes_check
      $error("if_fetch only supports BYTES == 4");
   end

   typedef enum logic {StIdle, StFetch} state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
   logic              fetch_jump_q, fetch_jump_d;
   logic [2:0]        issue_cnt_q, issue_cnt_d;
   logic [2:0]        recv_cnt_q, recv_cnt_d;
   logic              rd_pending_q, rd_pending_d;
   logic [31:0]       asm_q, asm_d;
   logic [31:0]       buf_q, buf_d;
   logic [ADDR_W-1:0] buf_pc_q, buf_pc_d;
   logic              buf_jump_q, buf_jump_d;
   logic              buf_valid_q, buf_valid_d;

   logic              hit;
   logic [31:0]       asm_merged;
   logic              word_done;

   logic unused_stall;
   assign unused_stall = ^{stall[4:2], stall[0]};

   assign hit = buf_valid_q && (buf_pc_q == pc_i);

   // Partial word with the returning byte (if any) merged into its lane.
   always_comb begin
      asm_merged = asm_q;
      if (rd_pending_q) begin
         unique case (recv_cnt_q[1:0])
            2'd0: asm_merged[7:0]   = mem_din;
            2'd1: asm_merged[15:8]  = mem_din;
            2'd2: asm_merged[23:16] = mem_din;
            2'd3: asm_merged[31:24] = mem_din;
            default: asm_merged = asm_q;
         endcase
      end
   end

   // Fourth byte arrives now, or arrived earlier and completion was held by stall.
   assign word_done = rd_pending_q ? (recv_cnt_q == 3'd3) : (recv_cnt_q == 3'd4);

   always_comb begin
      state_d      = state_q;
      fetch_pc_d   = fetch_pc_q;
      fetch_jump_d = fetch_jump_q;
      issue_cnt_d  = issue_cnt_q;
      recv_cnt_d   = recv_cnt_q;
      rd_pending_d = 1'b0;
      asm_d        = asm_q;
      buf_d        = buf_q;
      buf_pc_d     = buf_pc_q;
      buf_jump_d   = buf_jump_q;
      buf_valid_d  = buf_valid_q;
      mem_rd_en    = 1'b0;
      mem_a        = '0;

      unique case (state_q)
         StIdle: begin
            if (!hit) begin
               fetch_pc_d   = pc_i;
               fetch_jump_d = jump_i;
               issue_cnt_d  = 3'd0;
               recv_cnt_d   = 3'd0;
               asm_d        = 32'd0;
               state_d      = StFetch;
            end
         end
         StFetch: begin
            if (pc_i != fetch_pc_q) begin
               // Abort: drop partial bytes and any byte still in flight.
               state_d = StIdle;
            end else begin
               if (issue_cnt_q < 3'd4) begin
                  mem_rd_en = 1'b1;
                  mem_a     = fetch_pc_q + ADDR_W'(issue_cnt_q);
                  if (mem_grant) begin
                     issue_cnt_d  = issue_cnt_q + 3'd1;
                     rd_pending_d = 1'b1;
                  end
               end
               if (rd_pending_q) begin
                  asm_d      = asm_merged;
                  recv_cnt_d = recv_cnt_q + 3'd1;
               end
               if (word_done && !stall[1]) begin
                  buf_d       = asm_merged;
                  buf_pc_d    = fetch_pc_q;
                  buf_jump_d  = fetch_jump_q;
                  buf_valid_d = 1'b1;
                  state_d     = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= StIdle;
         fetch_pc_q   <= '0;
         fetch_jump_q <= 1'b0;
         issue_cnt_q  <= 3'd0;
         recv_cnt_q   <= 3'd0;
         rd_pending_q <= 1'b0;
         asm_q        <= 32'd0;
         buf_q        <= 32'd0;
         buf_pc_q     <= '0;
         buf_jump_q   <= 1'b0;
         buf_valid_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         fetch_pc_q   <= fetch_pc_d;
         fetch_jump_q <= fetch_jump_d;
         issue_cnt_q  <= issue_cnt_d;
         recv_cnt_q   <= recv_cnt_d;
         rd_pending_q <= rd_pending_d;
         asm_q        <= asm_d;
         buf_q        <= buf_d;
         buf_pc_q     <= buf_pc_d;
         buf_jump_q   <= buf_jump_d;
         buf_valid_q  <= buf_valid_d;
      end
   end

   assign if_stallreq  = !hit;
   assign inst_valid_o = hit;
   assign inst_o       = buf_q;
   assign inst_pc_o    = buf_pc_q;
   assign inst_jump_o  = buf_jump_q;

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: directed scenarios followed by random
// pc/grant/stall/reset traffic, checked every cycle against a fetch model.
module tb_if_fetch;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc_i;
   logic        jump_i;
   logic [4:0]  stall;
   logic [31:0] mem_a;
   logic        mem_rd_en;
   logic        mem_grant;
   logic [7:0]  mem_din;
   logic        if_stallreq;
   logic [31:0] inst_o;
   logic [31:0] inst_pc_o;
   logic        inst_jump_o;
   logic        inst_valid_o;

   if_fetch #(.ADDR_W(32), .BYTES(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .pc_i         (pc_i),
      .jump_i       (jump_i),
      .stall        (stall),
      .mem_a        (mem_a),
      .mem_rd_en    (mem_rd_en),
      .mem_grant    (mem_grant),
      .mem_din      (mem_din),
      .if_stallreq  (if_stallreq),
      .inst_o       (inst_o),
      .inst_pc_o    (inst_pc_o),
      .inst_jump_o  (inst_jump_o),
      .inst_valid_o (inst_valid_o)
   );

   always #5 clk = ~clk;

   // Stimulus applied at each falling edge.
   logic        s_rst = 1'b0;
   logic [31:0] s_pc = 32'd0;
   logic        s_jump = 1'b0;
   logic [4:0]  s_stall = 5'd0;
   logic        s_grant = 1'b1;
   logic [7:0]  din_next = 8'd0;

   logic [7:0]  mem [0:255];

   int n_checks = 0;
   int n_pass = 0;
   bit chk_en = 1'b0;

   // Fetch model: what fetch is in progress and what instruction is buffered.
   bit          m_active = 1'b0;
   logic [31:0] m_fpc = 32'd0;
   bit          m_fjump = 1'b0;
   int          m_issued = 0;
   int          m_recv = 0;
   bit          m_pend = 1'b0;
   bit          m_bvalid = 1'b0;
   logic [31:0] m_bpc = 32'd0;
   logic [31:0] m_binst = 32'd0;
   bit          m_bjump = 1'b0;

   function automatic logic [31:0] word_at(input logic [31:0] a);
      logic [31:0] a1, a2, a3;
      a1 = a + 32'd1;
      a2 = a + 32'd2;
      a3 = a + 32'd3;
      return {mem[a3[7:0]], mem[a2[7:0]], mem[a1[7:0]], mem[a[7:0]]};
   endfunction

   function automatic void chk(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
   endfunction

   function automatic bit m_hit();
      return m_bvalid && (m_bpc == s_pc);
   endfunction

   function automatic bit m_req();
      return m_active && (m_issued < 4) && (s_pc == m_fpc);
   endfunction

   function automatic void compare();
      logic [31:0] ea;
      ea = m_req() ? m_fpc + 32'(m_issued) : 32'd0;
      chk("mem_rd_en", {31'd0, mem_rd_en}, {31'd0, m_req()});
      chk("mem_a", mem_a, ea);
      chk("if_stallreq", {31'd0, if_stallreq}, {31'd0, !m_hit()});
      chk("inst_valid_o", {31'd0, inst_valid_o}, {31'd0, m_hit()});
      chk("inst_o", inst_o, m_binst);
      chk("inst_pc_o", inst_pc_o, m_bpc);
      chk("inst_jump_o", {31'd0, inst_jump_o}, {31'd0, m_bjump});
   endfunction

   // Advance the model across the coming rising edge.
   function automatic void model_step();
      bit acc;
      acc = m_req() && s_grant;
      if (!s_rst) begin
         m_active = 1'b0; m_pend = 1'b0; m_bvalid = 1'b0;
         m_bpc = 32'd0; m_binst = 32'd0; m_bjump = 1'b0;
      end else if (!m_active) begin
         if (!m_hit()) begin
            m_active = 1'b1; m_fpc = s_pc; m_fjump = s_jump;
            m_issued = 0; m_recv = 0; m_pend = 1'b0;
         end
      end else if (s_pc != m_fpc) begin
         m_active = 1'b0; m_pend = 1'b0;
      end else begin
         if (m_pend) m_recv++;
         if (m_recv == 4 && !s_stall[1]) begin
            m_bvalid = 1'b1; m_bpc = m_fpc; m_bjump = m_fjump;
            m_binst = word_at(m_fpc); m_active = 1'b0;
         end
         if (acc) m_issued++;
         m_pend = acc;
      end
   endfunction

   // One clock cycle: apply stimulus, settle, check, then model the edge.
   task automatic cyc();
      @(negedge clk);
      rst = s_rst; pc_i = s_pc; jump_i = s_jump; stall = s_stall;
      mem_grant = s_grant; mem_din = din_next;
      #1;
      if (chk_en) compare();
      // Memory: return the accepted byte next cycle, garbage otherwise.
      if (mem_rd_en === 1'b1 && mem_grant) din_next = mem[mem_a[7:0]];
      else din_next = 8'($urandom);
      model_step();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   logic [31:0] pc_tab [0:9];

   initial begin
      rst = 1'b0; pc_i = 32'd0; jump_i = 1'b0; stall = 5'd0;
      mem_grant = 1'b0; mem_din = 8'd0;
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      mem[0] = 8'h13; mem[1] = 8'h05; mem[2] = 8'h10; mem[3] = 8'h00;
      mem[8] = 8'h11; mem[9] = 8'h22; mem[10] = 8'h33; mem[11] = 8'h44;
      mem[8'h40] = 8'hEF; mem[8'h41] = 8'hBE; mem[8'h42] = 8'hAD; mem[8'h43] = 8'hDE;
      chk("model word 0", word_at(32'd0), 32'h00100513);

      // Reset; compare from the second reset cycle on.
      cyc();
      chk_en = 1'b1;
      cyc();

      // 1: first fetch at pc 0 with continuous grant.
      s_rst = 1'b1; s_pc = 32'd0; s_grant = 1'b1;
      cyc();
      for (int i = 0; i < 4; i++) begin
         cyc();
         chk("t1 mem_a", mem_a, 32'(i));
      end
      cyc();
      chk("t1 stallreq c5", {31'd0, if_stallreq}, 32'd1);
      cyc();
      chk("t1 inst_o", inst_o, 32'h00100513);
      chk("t1 valid", {31'd0, inst_valid_o}, 32'd1);

      // 2: step to pc 4.
      s_pc = 32'd4;
      cyc();
      chk("t2 valid c0", {31'd0, inst_valid_o}, 32'd0);
      cyc();
      chk("t2 mem_a", mem_a, 32'd4);
      run(5);

      // 3: grant low in cycles 2 and 3 of fetch at 0x8.
      s_pc = 32'd8;
      cyc(); cyc();
      s_grant = 1'b0; cyc(); chk("t3 hold c2", mem_a, 32'd9);
      cyc(); chk("t3 hold c3", mem_a, 32'd9);
      s_grant = 1'b1; cyc(); chk("t3 hold c4", mem_a, 32'd9);
      cyc(); cyc();
      cyc(); chk("t3 valid c7", {31'd0, inst_valid_o}, 32'd0);
      cyc(); chk("t3 valid c8", {31'd0, inst_valid_o}, 32'd1);
      chk("t3 inst_o", inst_o, 32'h44332211);

      // 4: jump away after two bytes received.
      s_pc = 32'h10;
      run(4);
      s_pc = 32'h40; s_jump = 1'b1;
      cyc(); chk("t4 abort rd_en", {31'd0, mem_rd_en}, 32'd0);
      cyc();
      s_jump = 1'b0;
      run(6);
      chk("t4 inst_o", inst_o, 32'hDEADBEEF);
      chk("t4 jump", {31'd0, inst_jump_o}, 32'd1);

      // 5: stall[1] held across the fourth-byte cycle.
      s_pc = 32'h20; s_stall = 5'b00010;
      run(8);
      chk("t5 valid stalled", {31'd0, inst_valid_o}, 32'd0);
      chk("t5 pc held", inst_pc_o, 32'h40);
      s_stall = 5'd0;
      cyc(); cyc();
      chk("t5 valid after", {31'd0, inst_valid_o}, 32'd1);
      chk("t5 pc after", inst_pc_o, 32'h20);

      // 6: reset mid-fetch.
      s_pc = 32'h30;
      run(3);
      s_rst = 1'b0; cyc();
      s_rst = 1'b1; cyc();
      chk("t6 inst_o", inst_o, 32'd0);
      chk("t6 valid", {31'd0, inst_valid_o}, 32'd0);
      chk("t6 rd_en", {31'd0, mem_rd_en}, 32'd0);
      run(6);
      chk("t6 refetch pc", inst_pc_o, 32'h30);
      chk("t6 refetch valid", {31'd0, inst_valid_o}, 32'd1);

      // Random traffic, including an address-wrapping pc.
      pc_tab[0] = 32'h0;  pc_tab[1] = 32'h4;  pc_tab[2] = 32'h8;  pc_tab[3] = 32'h10;
      pc_tab[4] = 32'h3c; pc_tab[5] = 32'h40; pc_tab[6] = 32'h7d; pc_tab[7] = 32'hc0;
      pc_tab[8] = 32'hFFFF_FFFE; pc_tab[9] = 32'h1234_5678;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 5) == 0) s_pc = pc_tab[$urandom_range(0, 9)];
         s_jump  = 1'($urandom);
         s_grant = ($urandom_range(0, 9) < 7);
         s_stall = 5'($urandom) & (($urandom_range(0, 4) == 0) ? 5'b11111 : 5'b11101);
         s_rst   = ($urandom_range(0, 199) != 0);
         cyc();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
